// File: rtl/ysyx_23060221_ifu_if.sv
// Fetch-unit bus bundle: AR/R instruction-memory channels, IFU->IDU handoff
// and the next-PC return path, viewed from the fetcher (master) or its environment (slave).
interface ysyx_23060221_ifu_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        IFU_valid;
  logic        IDU_ready;
  logic [31:0] npc;
  logic        npc_valid;
  logic        npc_ready;

  modport master (
    output araddr, arvalid, rready, inst, pc, IFU_valid, npc_ready,
    input  arready, rdata, rresp, rvalid, IDU_ready, npc, npc_valid
  );

  modport slave (
    input  araddr, arvalid, rready, inst, pc, IFU_valid, npc_ready,
    output arready, rdata, rresp, rvalid, IDU_ready, npc, npc_valid
  );
endinterface

// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch unit: one fetch in flight, hands inst/pc to the decoder and
// waits for the next PC before issuing the following request.
module ysyx_23060221_ifu #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          FETCH_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_23060221_ifu_if.master    bus,
  output logic                   fault,
  output logic [FETCH_CNT_W-1:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    RESP     = 3'd2,
    HOLD     = 3'd3,
    WAIT_NPC = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t                 state_reg, state_next;
  logic [31:0]            pc_reg, pc_next;
  logic [31:0]            inst_reg, inst_next;
  logic                   fault_reg, fault_next;
  logic [FETCH_CNT_W-1:0] fetch_cnt_reg, fetch_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      inst_reg      <= 32'h0;
      fault_reg     <= 1'b0;
      fetch_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      inst_reg      <= inst_next;
      fault_reg     <= fault_next;
      fetch_cnt_reg <= fetch_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    inst_next      = inst_reg;
    fault_next     = fault_reg;
    fetch_cnt_next = fetch_cnt_reg;
    unique case (state_reg)
      IDLE: state_next = REQ;
      // rvalid is deliberately not looked at here, even if it coincides with arready.
      REQ: begin
        if (bus.arready) state_next = RESP;
      end
      RESP: begin
        if (bus.rvalid) begin
          if (bus.rresp == 2'b00) begin
            inst_next  = bus.rdata;
            state_next = HOLD;
          end else begin
            fault_next = 1'b1;
            state_next = FAULT;
          end
        end
      end
      HOLD: begin
        if (bus.IDU_ready) begin
          fetch_cnt_next = fetch_cnt_reg + 1'b1;
          state_next     = WAIT_NPC;
        end
      end
      WAIT_NPC: begin
        if (bus.npc_valid) begin
          pc_next = bus.npc;
          // A misaligned target is recorded in pc so the faulting address is visible.
          if (bus.npc[1:0] == 2'b00) begin
            state_next = REQ;
          end else begin
            fault_next = 1'b1;
            state_next = FAULT;
          end
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  assign bus.arvalid   = (state_reg == REQ);
  assign bus.rready    = (state_reg == RESP);
  assign bus.IFU_valid = (state_reg == HOLD);
  assign bus.npc_ready = (state_reg == WAIT_NPC);
  assign bus.araddr    = pc_reg;
  assign bus.pc        = pc_reg;
  assign bus.inst      = inst_reg;
  assign fault         = fault_reg;
  assign fetch_cnt     = fetch_cnt_reg;

endmodule

// File: tb/tb_ysyx_23060221_ifu.sv
// Directed bench for the fetch unit: walks the FSM cycle by cycle against
// hand-derived expectations for handshakes, stalls, faults and reset.
module tb_ysyx_23060221_ifu;
  logic        clk;
  logic        rst;
  logic        fault;
  logic [31:0] fetch_cnt;

  int checks;
  int failures;
  int ar_acc;
  int ar_base;

  ysyx_23060221_ifu_if bus ();

  ysyx_23060221_ifu #(
    .RESET_PC    (32'h8000_0000),
    .FETCH_CNT_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .fault     (fault),
    .fetch_cnt (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accepted AR handshakes.
  always @(posedge clk) begin
    if (rst) ar_acc <= 0;
    else if (bus.arvalid && bus.arready) ar_acc <= ar_acc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.arready = 1'b0;
    bus.rdata = 32'h0;
    bus.rresp = 2'b00;
    bus.rvalid = 1'b0;
    bus.IDU_ready = 1'b0;
    bus.npc = 32'h0;
    bus.npc_valid = 1'b0;
    do_reset();

    // T1: zero-wait memory, first instruction
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rresp = 2'b00;
    bus.rdata = 32'h0000_0413; bus.IDU_ready = 1'b1;
    bus.npc = 32'h8000_0004; bus.npc_valid = 1'b1;
    check_eq("rst_arvalid", {31'h0, bus.arvalid}, 32'd0);
    check_eq("rst_rready", {31'h0, bus.rready}, 32'd0);
    check_eq("rst_ifu_valid", {31'h0, bus.IFU_valid}, 32'd0);
    check_eq("rst_npc_ready", {31'h0, bus.npc_ready}, 32'd0);
    check_eq("rst_pc", bus.pc, 32'h8000_0000);
    check_eq("rst_inst", bus.inst, 32'h0);
    check_eq("rst_fault", {31'h0, fault}, 32'd0);
    check_eq("rst_fetch_cnt", fetch_cnt, 32'd0);
    step();
    check_eq("t1_arvalid", {31'h0, bus.arvalid}, 32'd1);
    check_eq("t1_araddr", bus.araddr, 32'h8000_0000);
    step();
    check_eq("t1_rready", {31'h0, bus.rready}, 32'd1);
    check_eq("t1_arvalid_low", {31'h0, bus.arvalid}, 32'd0);
    step();
    check_eq("t1_ifu_valid", {31'h0, bus.IFU_valid}, 32'd1);
    check_eq("t1_inst", bus.inst, 32'h0000_0413);
    check_eq("t1_pc", bus.pc, 32'h8000_0000);
    step();
    check_eq("t1_npc_ready", {31'h0, bus.npc_ready}, 32'd1);
    check_eq("t1_fetch_cnt", fetch_cnt, 32'd1);
    bus.IDU_ready = 1'b0;
    bus.rdata = 32'h0010_0093;
    step();
    check_eq("t1_next_arvalid", {31'h0, bus.arvalid}, 32'd1);
    check_eq("t1_next_araddr", bus.araddr, 32'h8000_0004);

    // T2: decoder stall in HOLD
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_ifu_valid", {31'h0, bus.IFU_valid}, 32'd1);
      check_eq("t2_inst", bus.inst, 32'h0010_0093);
      check_eq("t2_pc", bus.pc, 32'h8000_0004);
      check_eq("t2_fetch_cnt", fetch_cnt, 32'd1);
      check_eq("t2_no_arvalid", {31'h0, bus.arvalid}, 32'd0);
      step();
    end
    bus.IDU_ready = 1'b1;
    bus.npc = 32'h8000_0008;
    step();
    check_eq("t2_fetch_cnt_inc", fetch_cnt, 32'd2);
    bus.arready = 1'b0;
    step();

    // T3: AR acceptance delayed 3 cycles
    ar_base = ar_acc;
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_arvalid", {31'h0, bus.arvalid}, 32'd1);
      check_eq("t3_araddr", bus.araddr, 32'h8000_0008);
      if (i == 3) bus.arready = 1'b1;
      step();
    end
    check_eq("t3_rready", {31'h0, bus.rready}, 32'd1);
    check_eq("t3_arvalid_low", {31'h0, bus.arvalid}, 32'd0);
    check_eq("t3_ar_accepts", ar_acc - ar_base, 32'd1);
    bus.rdata = 32'h0020_0113;
    step();
    check_eq("t3_inst", bus.inst, 32'h0020_0113);
    check_eq("t3_pc", bus.pc, 32'h8000_0008);
    bus.npc = 32'h8000_000c;
    step();
    step();
    step();

    // T4: error response on the data beat
    check_eq("t4_rready", {31'h0, bus.rready}, 32'd1);
    bus.rresp = 2'b10;
    bus.rdata = 32'hdead_beef;
    step();
    check_eq("t4_fault", {31'h0, fault}, 32'd1);
    check_eq("t4_inst_kept", bus.inst, 32'h0020_0113);
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_no_arvalid", {31'h0, bus.arvalid}, 32'd0);
      check_eq("t4_no_ifu_valid", {31'h0, bus.IFU_valid}, 32'd0);
      step();
    end
    check_eq("t4_fetch_cnt", fetch_cnt, 32'd3);

    // T5: misaligned next PC
    bus.rresp = 2'b00;
    do_reset();
    check_eq("t5_fault_cleared", {31'h0, fault}, 32'd0);
    bus.rdata = 32'h0000_0413;
    bus.npc = 32'h8000_0102;
    step();
    step();
    step();
    step();
    step();
    check_eq("t5_pc", bus.pc, 32'h8000_0102);
    check_eq("t5_fault", {31'h0, fault}, 32'd1);
    check_eq("t5_fetch_cnt", fetch_cnt, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_no_arvalid", {31'h0, bus.arvalid}, 32'd0);
      step();
    end

    // T6: reset while waiting in RESP, late rvalid ignored
    bus.npc = 32'h8000_0004;
    bus.rvalid = 1'b0;
    do_reset();
    step();
    step();
    check_eq("t6_in_resp", {31'h0, bus.rready}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 32'hcafe_f00d;
    check_eq("t6_rready", {31'h0, bus.rready}, 32'd0);
    check_eq("t6_pc", bus.pc, 32'h8000_0000);
    check_eq("t6_inst", bus.inst, 32'h0);
    check_eq("t6_fetch_cnt", fetch_cnt, 32'd0);
    step();
    check_eq("t6_araddr", bus.araddr, 32'h8000_0000);
    check_eq("t6_arvalid", {31'h0, bus.arvalid}, 32'd1);
    check_eq("t6_inst_ignored", bus.inst, 32'h0);
    step();
    step();
    check_eq("t6_ifu_valid", {31'h0, bus.IFU_valid}, 32'd1);
    check_eq("t6_inst_new", bus.inst, 32'hcafe_f00d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_23060221_ifu.md
Name: ysyx_23060221_ifu

Overview:
Instruction fetch unit: the producer end of the IFU→IDU valid/ready handshake.
- Holds the architectural PC and issues single-beat read requests to instruction memory over AR/R channels (AXI-lite style).
- Latches the returned word and presents inst/pc to the decoder, holding them until the decoder accepts.
- Waits for the next-PC handshake from the execute/writeback path before starting the next fetch.
- One instruction in flight; no prefetch.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
FETCH_CNT_W, 32, width of the fetch performance counter.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
araddr  out  32  read address; equals pc whenever arvalid=1.
arvalid  out  1  read request valid.
arready  in  1  memory accepts request.
rdata  in  32  read data.
rresp  in  2  read response; 2'b00 = OKAY, anything else = error.
rvalid  in  1  read data valid.
rready  out  1  fetcher ready for read data.
inst  out  32  fetched instruction to decoder.
pc  out  32  PC of inst.
IFU_valid  out  1  inst/pc valid toward decoder.
IDU_ready  in  1  decoder ready.
npc  in  32  next PC.
npc_valid  in  1  next PC valid.
npc_ready  out  1  fetcher accepts npc.
fault  out  1  sticky fetch fault.
fetch_cnt  out  FETCH_CNT_W  count of instructions handed to the decoder.

Behaviour:
- States: IDLE, REQ, RESP, HOLD, WAIT_NPC, FAULT.
- Reset (rst=1 at posedge):
  - state=IDLE, pc=RESET_PC, inst=0, fault=0, fetch_cnt=0.
  - All handshake outputs (arvalid, rready, IFU_valid, npc_ready) are 0 during and in the first cycle after reset.
  - Reset mid-transaction abandons it. Any later rvalid is ignored unless state=RESP.
- IDLE: next state REQ unconditionally.
- REQ:
  - arvalid=1, araddr=pc; araddr stays stable while arvalid=1 and arready=0.
  - arvalid&arready → RESP.
- RESP:
  - rready=1.
  - On rvalid with rresp==0: inst<=rdata → HOLD.
  - On rvalid with rresp!=0: fault<=1 → FAULT; inst is unchanged.
- HOLD:
  - IFU_valid=1; inst and pc stay stable until the handshake.
  - IFU_valid&IDU_ready → fetch_cnt<=fetch_cnt+1 (wraps modulo 2^FETCH_CNT_W) → WAIT_NPC.
- WAIT_NPC:
  - npc_ready=1.
  - On npc_valid: pc<=npc.
    - If npc[1:0]==0 → REQ.
    - Otherwise fault<=1 → FAULT.
  - npc_valid outside WAIT_NPC is ignored; the producer must hold it until npc_ready.
- FAULT: all handshake outputs 0; the block stays here until rst.
- Combinational outputs:
  - arvalid=(state==REQ), rready=(state==RESP), IFU_valid=(state==HOLD), npc_ready=(state==WAIT_NPC).
  - No output depends combinationally on an input.
- Latency, zero-wait memory (arready and rvalid high in the first cycle offered):
  - REQ→RESP→HOLD, so IFU_valid rises 2 cycles after arvalid first rises.
  - Minimum loop is 4 cycles per instruction (REQ, RESP, HOLD, WAIT_NPC).
- Simultaneous arready and rvalid in REQ: rvalid is ignored that cycle. Memory must present data no earlier than the cycle after AR acceptance.

Test Plan:
- Reset release, memory ready/valid every cycle, rdata=32'h00000413, IDU_ready=1, npc=32'h80000004 → araddr=32'h80000000 in the 2nd cycle after reset; IFU_valid high 2 cycles later with inst=32'h00000413, pc=32'h80000000; then araddr=32'h80000004; fetch_cnt=1.
- IDU_ready held 0 for 5 cycles in HOLD → IFU_valid, inst and pc stay constant; fetch_cnt stays unchanged; no arvalid.
- arready delayed 3 cycles → araddr stable for all 4 arvalid cycles; exactly one request is accepted.
- rresp=2'b10 on the data beat → fault=1 the next cycle; IFU_valid never asserts; arvalid stays 0 until rst.
- npc=32'h80000102 in WAIT_NPC → pc=32'h80000102, fault=1, no further arvalid.
- rst asserted while in RESP, then rvalid arrives → rvalid is ignored; pc=RESET_PC; fetch restarts at RESET_PC; fetch_cnt=0.
